// File: rtl/conv_encoder.sv
// Rate-1/2, constraint-length-4 convolutional encoder with 3-bit zero tail.
// One input bit in, one 2-bit symbol out, latency 1, with a valid/ready
// handshake on both sides. Frames are force-terminated at MAX_DATA bits
// so that data plus tail always fits one trellis memory bank.
module conv_encoder #(
    parameter logic [3:0] G0       = 4'b1111,
    parameter logic [3:0] G1       = 4'b1101,
    parameter logic [9:0] MAX_DATA = 10'd1021
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       d_in,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] d_out,
    output logic       out_last,
    output logic       frame_trunc
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t     state, state_nxt;
    logic [2:0] s;          // s[2] is the most recent input bit
    logic [9:0] data_cnt;   // data bits accepted so far in the open frame
    logic [1:0] tail_cnt;   // tail symbols already emitted

    logic       slot_free;
    logic       accept;
    logic       tail_go;
    logic       load;
    logic       b;
    logic       at_max;
    logic       tail_done;
    logic [3:0] u;

    // Handshake, encoder input selection and next-state logic
    always_comb begin
        slot_free = !out_valid || out_ready;
        // Held low during reset so nothing is offered while the block is cleared
        in_ready  = !rst && enable && (state != TAIL) && slot_free;
        accept    = in_valid && in_ready;
        tail_go   = enable && (state == TAIL) && slot_free;
        load      = accept || tail_go;
        // Tail cycles feed zeros; data cycles feed the input bit
        b         = accept && d_in;
        u         = {b, s};
        // The bit being accepted is the MAX_DATA-th of the frame
        at_max    = (data_cnt == MAX_DATA - 10'd1);
        tail_done = tail_go && (tail_cnt == 2'd2);

        state_nxt = state;
        case (state)
            IDLE, DATA: begin
                if (accept && (in_last || at_max))
                    state_nxt = TAIL;
                else if (accept)
                    state_nxt = DATA;
            end
            TAIL: begin
                if (tail_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable)
            state_nxt = IDLE;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Encoder shift register, counters and registered output symbol
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s           <= 3'b000;
            data_cnt    <= 10'd0;
            tail_cnt    <= 2'd0;
            out_valid   <= 1'b0;
            d_out       <= 2'b00;
            out_last    <= 1'b0;
            frame_trunc <= 1'b0;
        end else if (!enable) begin
            s           <= 3'b000;
            data_cnt    <= 10'd0;
            tail_cnt    <= 2'd0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_trunc <= 1'b0;
        end else begin
            // Forced termination only when the sender did not end the frame itself
            frame_trunc <= accept && !in_last && at_max;

            if (load) begin
                out_valid <= 1'b1;
                d_out     <= {^(u & G0), ^(u & G1)};
                out_last  <= tail_done;
                s         <= {b, s[2:1]};
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (accept)
                data_cnt <= (in_last || at_max) ? 10'd0 : data_cnt + 10'd1;

            if (tail_go)
                tail_cnt <= tail_done ? 2'd0 : tail_cnt + 2'd1;
        end
    end

endmodule
